scramble: RTL and testbench
===========================

SCRAMBLE -- requirements
Module: scramble

Interface
REQ-001 SHALL have parameter SEED, default 11'h7ff, meaning the non-zero LFSR value loaded on reset and on a zero-value seed load.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port unscrambled  input  2  plaintext bits; bit [1] is the earlier bit in time.
REQ-005 SHALL have port unscrambled_valid  input  2  bit count: 2'b00 none, 2'b01 one bit (in unscrambled[1]), 2'b10 two bits, 2'b11 treated as 2'b01.
REQ-006 SHALL have port bypass  input  1  when high, bits pass unscrambled while the LFSR keeps advancing.
REQ-007 SHALL have port seed_load  input  1  one-cycle strobe that loads seed into the LFSR.
REQ-008 SHALL have port seed  input  11  value loaded on seed_load.
REQ-009 SHALL have port scrambled  output  2  ciphertext, same bit ordering as unscrambled.
REQ-010 SHALL have port scrambled_valid  output  2  copy of unscrambled_valid delayed one cycle.
REQ-011 SHALL have port lfsr_fault  output  1  single-cycle pulse when an all-zero LFSR is detected and recovered.

Function
REQ-012 SHALL implement the 11-bit LFSR x^11 + x^9 + 1 (7.2.2): key bits k1 = lfsr[8]^lfsr[10] and k0 = lfsr[7]^lfsr[9].
REQ-013 SHALL compute scrambled_next = unscrambled ^ {k1,k0}, or unscrambled unchanged when bypass=1.
REQ-014 SHALL register scrambled and scrambled_valid, giving 1-cycle latency from input to output.
REQ-015 SHALL update the LFSR with valid=2'b01/11 as lfsr <= {lfsr[9:0], k1}.
REQ-016 SHALL update the LFSR with valid=2'b10 as lfsr <= {lfsr[8:0], k1, k0}.
REQ-017 SHALL hold the LFSR with valid=2'b00, and SHALL drive scrambled to 2'b00 in that case.
REQ-018 SHALL make bit positions not covered by valid (scrambled[0] when valid=2'b01) a don't-care; the bench SHALL NOT check them.
REQ-019 SHALL produce an identical keystream whether a given bit sequence is delivered 1 bit/cycle, 2 bits/cycle, or with gaps.
REQ-020 SHALL give seed_load priority over advancement: that cycle, lfsr <= seed, and no advance occurs for the bits in that cycle.
REQ-021 SHALL still scramble the same-cycle input bits with the pre-load LFSR.
REQ-022 SHALL load SEED instead when seed_load=1 and seed=0; that case SHALL NOT pulse lfsr_fault.
REQ-023 SHALL detect lfsr==0 when seed_load=0, reload SEED in place of the advance, and assert lfsr_fault for exactly that cycle.
REQ-024 SHALL scramble that cycle's input bits with key 2'b00 when lfsr==0 is detected.
REQ-025 SHALL let bypass affect only the output data, never the LFSR sequence or scrambled_valid.
REQ-026 SHALL make output, after a matching receive-side LFSR locks, descramble to the original plaintext at a 2-bit/cycle or 1-bit/cycle pace.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set lfsr=SEED, scrambled=0, scrambled_valid=0, and lfsr_fault=0.
REQ-028 SHALL give rst priority over seed_load, zero-detect and all inputs.
REQ-029 SHALL, on reset mid-stream, discard in-flight bits; the first bit after rst deasserts SHALL use key bits derived from SEED.

Verification
REQ-030 SHALL cover: SEED=7ff, reset, then unscrambled=2'b11, valid=2'b10 for 3 cycles -> scrambled=2'b11 on cycles 1-3 after input; LFSR after 3 cycles = 11'h7c0.
REQ-031 SHALL cover: the same 200-bit random plaintext sent 2 bits/cycle, then, after re-reset, 1 bit/cycle with random idle gaps -> identical ciphertext bit sequences.
REQ-032 SHALL cover: seed_load=1, seed=0 -> next-cycle LFSR=SEED, lfsr_fault stays 0; forced LFSR of 0 via hierarchical deposit -> lfsr_fault=1 for one cycle, LFSR=SEED next cycle.
REQ-033 SHALL cover: bypass=1 for 10 cycles of 2-bit input -> scrambled==unscrambled; on bypass=0, keystream continues as if bypass never asserted (compare against reference model).
REQ-034 SHALL cover: scrambler output looped into a descrambler, 1000 cycles of idle (all ones) then random data -> descrambler locks, and post-lock plaintext matches input exactly.
REQ-035 SHALL cover: rst asserted mid-packet with valid=2'b10 -> next cycle scrambled_valid=0, scrambled=0; first post-reset output matches the SEED-derived key.

Source files
------------

// File: rtl/scramble.sv
// Purpose : 2-bit/cycle additive scrambler, 11-bit LFSR x^11 + x^9 + 1.
// Latency : 1 cycle from unscrambled/unscrambled_valid to scrambled/scrambled_valid.
// Backpr. : none; every input cycle is accepted and the LFSR advances per valid bit.
// Ports   : clk, rst (sync, active-high); unscrambled[1:0] (bit 1 earliest),
//           unscrambled_valid[1:0] (00 none, 01/11 one bit in [1], 10 two bits);
//           bypass; seed_load/seed[10:0]; scrambled[1:0], scrambled_valid[1:0];
//           lfsr_fault (one-cycle pulse when an all-zero LFSR was recovered).
module scramble #(
   parameter logic [10:0] SEED = 11'h7ff
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  unscrambled,
   input  logic [1:0]  unscrambled_valid,
   input  logic        bypass,
   input  logic        seed_load,
   input  logic [10:0] seed,
   output logic [1:0]  scrambled,
   output logic [1:0]  scrambled_valid,
   output logic        lfsr_fault
);

   logic [10:0] r_lfsr;
   logic [1:0]  r_scrambled;
   logic [1:0]  r_scrambled_valid;
   logic        r_lfsr_fault;

   logic        w_zero;
   logic        w_k1;
   logic        w_k0;
   logic        w_one;
   logic        w_two;
   logic [1:0]  w_key;
   logic [1:0]  w_data;
   logic [10:0] w_lfsr_adv;
   logic [10:0] w_seed_val;

   always_comb begin
      w_zero     = (r_lfsr == 11'd0);
      // k1 keys the earlier bit; k0 is what k1 becomes after one shift,
      // so the 2-bit step equals two 1-bit steps.
      w_k1       = r_lfsr[8] ^ r_lfsr[10];
      w_k0       = r_lfsr[7] ^ r_lfsr[9];
      w_key      = w_zero ? 2'b00 : {w_k1, w_k0};
      w_two      = (unscrambled_valid == 2'b10);
      w_one      = unscrambled_valid[0];
      // A zero seed would lock the LFSR, so substitute the default.
      w_seed_val = (seed == 11'd0) ? SEED : seed;

      w_lfsr_adv = r_lfsr;
      if (w_two) begin
         w_lfsr_adv = {r_lfsr[8:0], w_k1, w_k0};
      end else if (w_one) begin
         w_lfsr_adv = {r_lfsr[9:0], w_k1};
      end

      w_data = bypass ? unscrambled : (unscrambled ^ w_key);
      if (w_one) begin
         w_data[0] = 1'b0;
      end else if (!w_two) begin
         w_data = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr            <= SEED;
         r_scrambled       <= 2'b00;
         r_scrambled_valid <= 2'b00;
         r_lfsr_fault      <= 1'b0;
      end else begin
         r_scrambled       <= w_data;
         r_scrambled_valid <= unscrambled_valid;
         r_lfsr_fault      <= 1'b0;
         if (seed_load) begin
            // Same-cycle bits were already keyed with the pre-load state.
            r_lfsr <= w_seed_val;
         end else if (w_zero) begin
            r_lfsr       <= SEED;
            r_lfsr_fault <= 1'b1;
         end else begin
            r_lfsr <= w_lfsr_adv;
         end
      end
   end

   assign scrambled       = r_scrambled;
   assign scrambled_valid = r_scrambled_valid;
   assign lfsr_fault      = r_lfsr_fault;

endmodule

// File: tb/tb_scramble.sv
// Purpose : directed self-checking bench for scramble against a bit-serial keystream model.
// Latency : outputs sampled 1 time unit after the rising edge that registers them.
// Backpr. : none exercised; the DUT accepts every cycle.
module tb_scramble;

   localparam logic [10:0] SEED = 11'h7ff;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  unscrambled;
   logic [1:0]  unscrambled_valid;
   logic        bypass;
   logic        seed_load;
   logic [10:0] seed;
   logic [1:0]  scrambled;
   logic [1:0]  scrambled_valid;
   logic        lfsr_fault;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [10:0] m_lfsr;
   bit          cap_en;
   logic        cap_q[$];
   logic        qa[$];
   logic        tx_q[$];
   logic        pt[200];

   scramble #(.SEED(SEED)) dut (
      .clk               (clk),
      .rst               (rst),
      .unscrambled       (unscrambled),
      .unscrambled_valid (unscrambled_valid),
      .bypass            (bypass),
      .seed_load         (seed_load),
      .seed              (seed),
      .scrambled         (scrambled),
      .scrambled_valid   (scrambled_valid),
      .lfsr_fault        (lfsr_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock, then capture ciphertext bits in time order.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (cap_en) begin
         case (scrambled_valid)
            2'b10: begin
               cap_q.push_back(scrambled[1]);
               cap_q.push_back(scrambled[0]);
            end
            2'b01, 2'b11: cap_q.push_back(scrambled[1]);
            default: ;
         endcase
      end
   endtask

   task automatic idle_inputs();
      unscrambled       = 2'b00;
      unscrambled_valid = 2'b00;
      bypass            = 1'b0;
      seed_load         = 1'b0;
      seed              = 11'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      m_lfsr = SEED;
   endtask

   // Bit-serial reference: each key bit is fed back into the register.
   task automatic next_key(output logic k);
      k      = m_lfsr[8] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[9:0], k};
   endtask

   task automatic key2(output logic [1:0] k);
      logic a;
      logic b;
      next_key(a);
      next_key(b);
      k = {a, b};
   endtask

   initial begin
      logic [1:0]  k;
      logic [1:0]  u;
      logic        kb;
      int          mis;
      int          mis_m;
      logic [10:0] rl;
      int          good;
      bit          locked;
      int          lock_idx;
      int          errs;

      idle_inputs();
      rst    = 1'b1;
      cap_en = 1'b0;

      // Reset state
      cycle();
      rst    = 1'b0;
      m_lfsr = SEED;
      check("rst_scr", 32'(scrambled), 32'h0);
      check("rst_vld", 32'(scrambled_valid), 32'h0);
      check("rst_fault", 32'(lfsr_fault), 32'h0);
      check("rst_lfsr", 32'(dut.r_lfsr), 32'(SEED));

      // All-ones input, two bits per cycle, from SEED=7ff: keys are zero
      for (int i = 0; i < 3; i++) begin
         unscrambled       = 2'b11;
         unscrambled_valid = 2'b10;
         cycle();
         check("ones_scr", 32'(scrambled), 32'h3);
         check("ones_vld", 32'(scrambled_valid), 32'h2);
      end
      check("ones_lfsr", 32'(dut.r_lfsr), 32'h7c0);

      // Same 200 bits at 2 bits/cycle, then 1 bit/cycle with gaps
      for (int i = 0; i < 200; i++) pt[i] = 1'($urandom_range(0, 1));
      do_reset();
      cap_q.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         unscrambled       = {pt[2*i], pt[2*i+1]};
         unscrambled_valid = 2'b10;
         cycle();
      end
      qa = cap_q;
      cap_en = 1'b0;
      do_reset();
      cap_q.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int gaps;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            idle_inputs();
            cycle();
            check("gap_scr", 32'(scrambled), 32'h0);
         end
         unscrambled       = {pt[i], 1'($urandom_range(0, 1))};
         unscrambled_valid = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
         cycle();
      end
      idle_inputs();
      cap_en = 1'b0;
      check("pace_len_a", 32'(qa.size()), 32'd200);
      check("pace_len_b", 32'(cap_q.size()), 32'd200);
      m_lfsr = SEED;
      mis    = 0;
      mis_m  = 0;
      for (int i = 0; i < 200; i++) begin
         next_key(kb);
         if (i < qa.size() && i < cap_q.size() && qa[i] !== cap_q[i]) mis++;
         if (i < qa.size() && qa[i] !== (pt[i] ^ kb)) mis_m++;
      end
      check("pace_equal", 32'(mis), 32'd0);
      check("pace_model", 32'(mis_m), 32'd0);

      // Seed load: same-cycle bits use pre-load key, no advance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         unscrambled       = 2'b00;
         unscrambled_valid = 2'b10;
         cycle();
         key2(k);
      end
      unscrambled       = 2'b10;
      unscrambled_valid = 2'b10;
      seed_load         = 1'b1;
      seed              = 11'h5a3;
      cycle();
      key2(k);
      check("sl_scr", 32'(scrambled), 32'(2'b10 ^ k));
      check("sl_lfsr", 32'(dut.r_lfsr), 32'h5a3);
      m_lfsr    = 11'h5a3;
      seed_load = 1'b0;
      unscrambled = 2'b01;
      cycle();
      key2(k);
      check("sl_next", 32'(scrambled), 32'(2'b01 ^ k));
      // Zero seed falls back to SEED, without a fault
      idle_inputs();
      seed_load = 1'b1;
      seed      = 11'd0;
      cycle();
      check("sl0_lfsr", 32'(dut.r_lfsr), 32'(SEED));
      check("sl0_fault", 32'(lfsr_fault), 32'h0);
      idle_inputs();
      cycle();
      check("sl0_fault2", 32'(lfsr_fault), 32'h0);

      // Forced zero LFSR: recovered with a one-cycle fault pulse, key 00
      dut.r_lfsr        = 11'd0;
      unscrambled       = 2'b10;
      unscrambled_valid = 2'b10;
      cycle();
      check("z_scr", 32'(scrambled), 32'h2);
      check("z_fault", 32'(lfsr_fault), 32'h1);
      check("z_lfsr", 32'(dut.r_lfsr), 32'(SEED));
      idle_inputs();
      cycle();
      check("z_fault_end", 32'(lfsr_fault), 32'h0);

      // Bypass: data passes through, keystream keeps advancing
      do_reset();
      seed_load = 1'b1;
      seed      = 11'h5a3;
      cycle();
      m_lfsr    = 11'h5a3;
      seed_load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         u                 = 2'($urandom_range(0, 3));
         unscrambled       = u;
         unscrambled_valid = 2'b10;
         bypass            = (i < 10);
         cycle();
         key2(k);
         if (i < 10) check("byp_scr", 32'(scrambled), 32'(u));
         else        check("post_byp", 32'(scrambled), 32'(u ^ k));
      end
      check("byp_vld", 32'(scrambled_valid), 32'h2);
      idle_inputs();

      // Loop into a descrambler that locks on idle ones
      do_reset();
      cap_q.delete();
      tx_q.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         u = (i < 1000) ? 2'b11 : 2'($urandom_range(0, 3));
         unscrambled       = u;
         unscrambled_valid = 2'b10;
         tx_q.push_back(u[1]);
         tx_q.push_back(u[0]);
         cycle();
      end
      idle_inputs();
      cap_en   = 1'b0;
      rl       = 11'd0;
      good     = 0;
      locked   = 1'b0;
      lock_idx = -1;
      errs     = 0;
      for (int i = 0; i < cap_q.size(); i++) begin
         if (!locked) begin
            kb = ~cap_q[i];
            if ((rl[8] ^ rl[10]) == kb) good++;
            else good = 0;
            rl = {rl[9:0], kb};
            if (good >= 40) begin
               locked   = 1'b1;
               lock_idx = i;
            end
         end else begin
            kb = rl[8] ^ rl[10];
            rl = {rl[9:0], kb};
            if ((cap_q[i] ^ kb) !== tx_q[i]) errs++;
         end
      end
      check("rx_len", 32'(cap_q.size()), 32'd2400);
      check("rx_locked", 32'(locked), 32'h1);
      check("rx_lock_in_idle", 32'(lock_idx >= 0 && lock_idx < 2000), 32'h1);
      check("rx_data", 32'(errs), 32'd0);

      // Reset mid-packet discards bits and restarts from SEED
      for (int i = 0; i < 4; i++) begin
         unscrambled       = 2'b01;
         unscrambled_valid = 2'b10;
         cycle();
      end
      rst               = 1'b1;
      unscrambled       = 2'b11;
      unscrambled_valid = 2'b10;
      cycle();
      check("mid_rst_vld", 32'(scrambled_valid), 32'h0);
      check("mid_rst_scr", 32'(scrambled), 32'h0);
      check("mid_rst_lfsr", 32'(dut.r_lfsr), 32'(SEED));
      rst    = 1'b0;
      m_lfsr = SEED;
      cycle();
      key2(k);
      check("post_rst_scr", 32'(scrambled), 32'(2'b11 ^ k));
      check("post_rst_lfsr", 32'(dut.r_lfsr), 32'h7fc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
